// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the parametrised data memory (dm_param).
package dm_pkg;

  typedef enum logic [1:0] {
    DM_SZ_BYTE  = 2'd0,
    DM_SZ_HALF  = 2'd1,
    DM_SZ_WORD  = 2'd2,
    DM_SZ_DWORD = 2'd3
  } dm_size_e;

  typedef enum logic {
    DM_ST_INIT = 1'b0,
    DM_ST_RUN  = 1'b1
  } dm_state_e;

  localparam int DM_MAX_LANES = 8;

  // Byte-lane enable for an access of 2**size bytes starting at lane ofs.
  function automatic logic [DM_MAX_LANES-1:0] dm_lane_mask(input logic [1:0] size,
                                                          input logic [2:0] ofs);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << ofs;
    return m[DM_MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/dm_param_if.sv
// Request/response bus between a datapath master and the dm_param memory.
interface dm_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 12
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             init_done;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, init_done
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for stores, load extraction/extension and
// misalignment detection for dm_param.
module dm_lane_align
  import dm_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int LANES = WIDTH / 8,
  localparam int OFS   = $clog2(LANES)
) (
  input  logic [1:0]       size,
  input  logic [OFS-1:0]   ofs,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] wdata_lane,
  output logic [LANES-1:0] lane_mask,
  output logic             err,
  input  logic [1:0]       rd_size,
  input  logic [OFS-1:0]   rd_ofs,
  input  logic             rd_signed,
  input  logic [WIDTH-1:0] rd_word,
  output logic [WIDTH-1:0] rd_data
);

  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       sz,
                                              input logic             sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [WIDTH-1:0]   r;
    b = signed'(v[7:0]);
    h = signed'(v[15:0]);
    w = signed'(v[31:0]);
    r = v;
    case (sz)
      DM_SZ_BYTE: if (sgn) r = WIDTH'(b); else r = WIDTH'(v[7:0]);
      DM_SZ_HALF: if (sgn) r = WIDTH'(h); else r = WIDTH'(v[15:0]);
      DM_SZ_WORD: if (sgn) r = WIDTH'(w); else r = WIDTH'(v[31:0]);
      default:    r = v;
    endcase
    return r;
  endfunction

  logic [2:0]              ofs3;
  logic [2:0]              align_mask;
  logic                    illegal;
  logic [DM_MAX_LANES-1:0] mask_full;

  always_comb begin
    ofs3 = 3'(ofs);
    case (size)
      DM_SZ_BYTE: align_mask = 3'b000;
      DM_SZ_HALF: align_mask = 3'b001;
      DM_SZ_WORD: align_mask = 3'b011;
      default:    align_mask = 3'b111;
    endcase
    // Sizes wider than the word cannot be served at all, aligned or not.
    illegal    = ({1'b0, size} > 3'(OFS));
    err        = illegal | (|(ofs3 & align_mask));
    mask_full  = dm_lane_mask(size, ofs3);
    lane_mask  = mask_full[LANES-1:0];
    wdata_lane = wdata << {ofs, 3'b000};
    rd_data    = extend(rd_word >> {rd_ofs, 3'b000}, rd_size, rd_signed);
  end

endmodule

// File: rtl/dm_param.sv
// Parametrised byte-addressed data memory with init sweep and fixed read latency.
// Optional build macro DM_INIT_EN: zero-fill sweep of all words after reset.
module dm_param
  import dm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input logic       clk,
  input logic       rst_n,
  dm_param_if.slave bus
);

  localparam int LANES = WIDTH / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int IW    = $clog2(DEPTH);
  localparam int AW    = IW + OFS;

  dm_state_e state, state_nxt;
  logic      ready;
  logic      accept;

`ifdef DM_INIT_EN
  logic [IW-1:0] cnt;
  logic          init_wr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DM_ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef DM_INIT_EN
    init_wr   = 1'b0;
`endif
    case (state)
      DM_ST_INIT: begin
`ifdef DM_INIT_EN
        init_wr = 1'b1;
        if (cnt == IW'(DEPTH - 1)) state_nxt = DM_ST_RUN;
`else
        state_nxt = DM_ST_RUN;
`endif
      end
      default: state_nxt = DM_ST_RUN;
    endcase
  end

`ifdef DM_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (init_wr) cnt <= cnt + 1'b1;
  end
`endif

  assign ready         = (state == DM_ST_RUN);
  assign bus.req_ready = ready;
  assign bus.init_done = ready;
  assign accept        = bus.req_valid & ready;

  logic [OFS-1:0]   ofs;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] wdata_lane;
  logic [LANES-1:0] lane_mask;
  logic             err;

  assign ofs = bus.req_addr[OFS-1:0];
  assign idx = bus.req_addr[AW-1:OFS];

  logic             we_p0, err_p0, sgn_p0, vld_p0;
  logic [1:0]       size_p0;
  logic [OFS-1:0]   ofs_p0;
  logic [WIDTH-1:0] word_p0;
  logic [WIDTH-1:0] rd_ext_p0;
  logic [WIDTH-1:0] rdata_p0;

  dm_lane_align #(.WIDTH(WIDTH)) u_align (
    .size       (bus.req_size),
    .ofs        (ofs),
    .wdata      (bus.req_wdata),
    .wdata_lane (wdata_lane),
    .lane_mask  (lane_mask),
    .err        (err),
    .rd_size    (size_p0),
    .rd_ofs     (ofs_p0),
    .rd_signed  (sgn_p0),
    .rd_word    (word_p0),
    .rd_data    (rd_ext_p0)
  );

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
`ifdef DM_INIT_EN
    if (init_wr) mem[cnt] <= '0;
    else
`endif
    if (accept && bus.req_we && !err) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_mask[l]) mem[idx][8*l +: 8] <= wdata_lane[8*l +: 8];
      end
    end
  end

  // Stage p0: request captured and word read at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      we_p0   <= 1'b0;
      err_p0  <= 1'b0;
      sgn_p0  <= 1'b0;
      size_p0 <= '0;
      ofs_p0  <= '0;
      word_p0 <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        we_p0   <= bus.req_we;
        err_p0  <= err;
        sgn_p0  <= bus.req_signed;
        size_p0 <= bus.req_size;
        ofs_p0  <= ofs;
        word_p0 <= mem[idx];
      end
    end
  end

  assign rdata_p0 = (vld_p0 && !we_p0 && !err_p0) ? rd_ext_p0 : '0;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             vld_p1, err_p1;
      logic [WIDTH-1:0] rdata_p1;

      // Stage p1: extra register for the two-cycle read latency build.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1   <= 1'b0;
          err_p1   <= 1'b0;
          rdata_p1 <= '0;
        end else begin
          vld_p1   <= vld_p0;
          err_p1   <= vld_p0 & err_p0;
          rdata_p1 <= rdata_p0;
        end
      end

      assign bus.resp_valid = vld_p1;
      assign bus.resp_err   = err_p1;
      assign bus.resp_rdata = rdata_p1;
    end else begin : g_lat1
      assign bus.resp_valid = vld_p0;
      assign bus.resp_err   = vld_p0 & err_p0;
      assign bus.resp_rdata = rdata_p0;
    end
  endgenerate

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param (WIDTH=32, DEPTH=16, READ_LAT=2): vector table, corner
// sequences and random traffic against a byte-array reference model.
module tb_dm_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int AW    = 6;
`ifdef DM_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_param_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  dm_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t       q[$];
  logic [7:0] mem_m [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (q.size() == 0) chk("stale_resp", 32'(bus.resp_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("resp_missing", 32'(bus.resp_valid), 32'd1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_resp();
  endtask

  // Reference: memory as 64 bytes, access rules applied with plain arithmetic.
  task automatic model(input logic we, input logic [5:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    int     nb, ofs, a;
    longint v;
    nb  = 1 << size;
    ofs = int'(addr) % 4;
    a   = int'(addr);
    err = (nb > 4) || ((ofs % nb) != 0);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem_m[a + k] = wdata[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (longint'(mem_m[a + k]) << (8 * k));
        if (sgn && nb < 4 && v[8*nb-1]) v = v | -(longint'(1) << (8 * nb));
        rd = v[31:0];
      end
    end
  endtask

  task automatic send(input logic we, input logic [5:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] wdata,
                      input bit use_tbl, input logic [31:0] trd, input logic terr);
    logic [31:0] rd;
    logic        e;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    model(we, addr, size, sgn, wdata, rd, e);
    if (use_tbl) q.push_back('{cyc + LAT, trd, terr});
    else         q.push_back('{cyc + LAT, rd, e});
    tick();
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 3; i++) idle();
    chk("drain_empty", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
  endtask

  // A store held on the bus during INIT must be ignored.
  task automatic wait_init();
    for (int n = 1; n <= INIT_CYC; n++) begin
      tick();
      chk("ready_during_init", 32'(bus.req_ready), 32'(n >= INIT_CYC));
      if (n == INIT_CYC) begin
        chk("init_done", 32'(bus.init_done), 32'd1);
        bus.req_valid = 1'b0;
      end
    end
    clear_model();
`ifndef DM_INIT_EN
    for (int w = 0; w < DEPTH; w++) send(1'b1, 6'(w * 4), 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
`endif
  endtask

  vec_t tbl [16];

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_wdata  = '0;

    tbl[0]  = '{1'b1, 6'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 6'h12, 2'd0, 1'b0, 32'h00000055, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 6'h12, 2'd1, 1'b1, 32'h00000000, 32'hFFFFDE55, 1'b0};
    tbl[3]  = '{1'b0, 6'h13, 2'd0, 1'b0, 32'h00000000, 32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 6'h06, 2'd2, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
    tbl[5]  = '{1'b0, 6'h00, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
    tbl[6]  = '{1'b1, 6'h11, 2'd2, 1'b0, 32'h12345678, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 6'h13, 2'd1, 1'b0, 32'h0000FFFF, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 6'h10, 2'd2, 1'b0, 32'h00000000, 32'hDE55BEEF, 1'b0};
    tbl[9]  = '{1'b1, 6'h20, 2'd2, 1'b0, 32'hCAFEF00D, 32'h00000000, 1'b0};
    tbl[10] = '{1'b0, 6'h20, 2'd2, 1'b0, 32'h00000000, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{1'b0, 6'h22, 2'd1, 1'b1, 32'h00000000, 32'hFFFFCAFE, 1'b0};
    tbl[12] = '{1'b0, 6'h20, 2'd0, 1'b1, 32'h00000000, 32'h0000000D, 1'b0};
    tbl[13] = '{1'b0, 6'h21, 2'd0, 1'b1, 32'h00000000, 32'hFFFFFFF0, 1'b0};
    tbl[14] = '{1'b0, 6'h20, 2'd1, 1'b0, 32'h00000000, 32'h0000F00D, 1'b0};
    tbl[15] = '{1'b0, 6'h3C, 2'd2, 1'b1, 32'h00000000, 32'h00000000, 1'b0};

    repeat (3) tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 6'h3C;
    bus.req_size  = 2'd2;
    bus.req_wdata = 32'hFFFFFFFF;
    rst_n = 1'b1;
    wait_init();

    send(1'b0, 6'h3C, 2'd2, 1'b0, 32'd0, 1'b1, 32'h00000000, 1'b0);
    idle();

    for (int i = 0; i < 16; i++)
      send(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].wdata, 1'b1, tbl[i].rd, tbl[i].err);
    drain();

    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, 1'b0, 32'd0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();

    send(1'b0, 6'h10, 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'h20;
    bus.req_size  = 2'd2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("inflight_valid", 32'(bus.resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_drop_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset_drop_rdata", bus.resp_rdata, 32'd0);
    chk("reset_ready_low", 32'(bus.req_ready), 32'd0);
    q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_init();
    for (int i = 0; i < 6; i++) idle();
    send(1'b0, 6'h10, 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    send(1'b0, 6'h20, 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_param.md
Name: dm_param

Overview:
Parametrised data memory for the multi-cycle datapath, successor to the fixed 4K word memory.
- Byte-addressed request/response interface; width, depth and read latency are parameters.
- Computes byte lanes internally from size and address, and sign/zero-extends loads.
- Flags misaligned accesses with an error response.
- Sweeps all contents to zero after reset before accepting requests.

Parameters:
WIDTH, 32, data word width in bits; legal values 32 or 64; LANES = WIDTH/8, OFS = log2(LANES)
DEPTH, 1024, number of words; power of two; AW = log2(DEPTH) + OFS is the byte-address width
READ_LAT, 1, cycles from request accept to resp_valid; legal values 1 or 2

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  AW  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word32, 3 = dword64
req_signed  in  1  sign-extend load result
req_wdata  in  WIDTH  store data, right-justified
resp_valid  out  1  response strobe, one cycle per accepted request
resp_rdata  out  WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal-size request
init_done  out  1  high once the init sweep is complete

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0. State=INIT, sweep counter=0. Pipeline registers are cleared.
- FSM states: INIT -> RUN.
  - INIT: writes one zero word per cycle at the counter index, then increments.
  - INIT -> RUN: on the cycle the counter reaches DEPTH-1, that last write completes and the state moves to RUN. init_done and req_ready rise the next cycle, i.e. DEPTH cycles after rst_n deasserts.
  - RUN: req_ready=1 permanently. No back-pressure on the response side.
- Accept rule: accept = req_valid & req_ready. Requests presented while req_ready=0 are ignored, not queued.
- Byte count: nbytes = 1 << req_size. ofs = req_addr[OFS-1:0]. word index = req_addr[AW-1:OFS].
- Error conditions (resp_err=1):
  - ofs not a multiple of nbytes (misaligned);
  - nbytes > LANES (e.g. size 3 with WIDTH=32).
  - On error: no memory write, resp_rdata=0.
- Store: lane mask = ((1<<nbytes)-1) << ofs. Byte k of req_wdata is written to lane ofs+k, at the accepting posedge. Other lanes are unchanged.
- Load:
  - The word is read synchronously at the accepting posedge.
  - Result = word >> (8*ofs), truncated to 8*nbytes bits.
  - The result is sign-extended if req_signed, else zero-extended, to WIDTH. For nbytes = LANES the extension is a no-op.
- Latency: resp_valid is asserted exactly READ_LAT cycles after accept, for loads, stores and errors alike. Back-to-back accepts give back-to-back responses, in order.
- Store then load to the same word on consecutive accepts: the load returns the new data. No hazard window is allowed.
- rst_n asserted mid-operation: in-flight responses are discarded (resp_valid forced to 0 asynchronously) and the FSM re-enters INIT. Contents are re-cleared when DM_INIT_EN is defined.
- A store accepted on the same posedge that reset asserts is not guaranteed to land.

Optional Feature:
DM_INIT_EN
- Defined: the INIT sweep runs as described and takes DEPTH cycles.
- Undefined: no sweep. INIT lasts exactly one cycle after rst_n deasserts, then RUN. Contents are uninitialised (X in simulation).
- Both builds: init_done tracks the RUN state.

Decomposition:
- Package dm_pkg holds:
  - size encodings DM_SZ_BYTE/HALF/WORD/DWORD;
  - FSM state encodings DM_ST_INIT/DM_ST_RUN;
  - a function returning the lane mask from size and offset.
- One combinational sub-module, dm_lane_align. It contains store lane steering, load extraction and extension, and misalignment detection. The top level keeps the FSM, array and latency pipeline.

Test Plan:
1. Init sweep (DM_INIT_EN defined, DEPTH=16): release rst_n -> req_ready low for 16 cycles, then high. A load of addr 0x3C returns 0x00000000.
2. Store size=2 addr 0x10 data 0xDEADBEEF, then store size=0 addr 0x12 data 0x55, then signed load size=1 addr 0x12 -> resp_rdata 0xFFFFDE55. Unsigned load size=0 addr 0x13 -> 0x000000DE.
3. Misaligned load size=2 addr 0x06, and size=3 with WIDTH=32 -> resp_err=1, resp_rdata=0, memory unchanged.
4. READ_LAT=2, loads accepted on 4 consecutive cycles -> 4 consecutive resp_valid pulses exactly 2 cycles after each accept, data in order.
5. Store addr 0x20 then load addr 0x20 on the next cycle -> load returns the newly stored value.
6. Assert rst_n low with two responses in flight -> resp_valid drops immediately and no stale response appears after the re-init.
